// File: rtl/mips_pkg.sv
// Shared definitions for the instruction sequencer: FSM state encoding,
// the sequential PC step and the default trap vector.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_TRAP  = 2'b11
    } state_e;

    localparam logic [31:0] PC_STEP            = 32'd4;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h8000_0180;

    // Clears the two byte-offset bits so a redirect lands on a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/pc_sequencer_fetch_timer.sv
// Fetch wait counter: counts FETCH cycles that went by without an
// acknowledge and flags when the count reaches TIMEOUT.
module fetch_timer
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam int             CW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign o_expired = (count_q == LIMIT);

    // Clear wins over counting; the count stops once it reaches the limit.
    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_en && !o_expired) begin
            count_d = count_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction sequencer: fetches one word at the current PC, holds it for
// the datapath until it completes, then advances or redirects the PC.
// Optional trap support is built when PC_SEQUENCER_EXC_EN is defined.
//
// imem handshake: o_imem_req is high with o_imem_addr stable until a rising
// edge where i_imem_ack is also high; that edge transfers i_imem_data.
// An ack seen while o_imem_req is low is ignored.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          TIMEOUT    = 16,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_data,
    output logic [31:0] o_instr,
    output logic        o_instr_valid,
    input  logic        i_exec_done,
    input  logic        i_stall,
    input  logic        i_pcsrc,
    input  logic [31:0] i_nextpc,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_trap,
    output logic [31:0] o_epc
);

    state_e      state_q;
    state_e      state_d;
    logic        started_q;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] instr_q;
    logic [31:0] instr_d;
    logic [31:0] pc_plus4;
    logic [31:0] redir_pc;
    logic        ack_take;
    logic        advance;
    logic        tmo_expired;
    logic        timer_clear;
    logic        timer_en;

    assign pc_plus4    = pc_q + PC_STEP;
    assign redir_pc    = word_align(i_nextpc);
    assign ack_take    = o_imem_req && i_imem_ack;
    assign advance     = (state_q == ST_EXEC) && i_exec_done && !i_stall;

    assign o_pc        = pc_q;
    assign o_pc_plus4  = pc_plus4;
    assign o_imem_addr = pc_q;
    assign o_instr     = instr_q;

    // Counter sits at zero outside FETCH, so every FETCH entry starts fresh;
    // an expiry also restarts it for the retry.
    assign timer_clear = (state_q != ST_FETCH) || tmo_expired;
    assign timer_en    = (state_q == ST_FETCH) && !ack_take;

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_fetch_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (timer_clear),
        .i_en      (timer_en),
        .o_expired (tmo_expired)
    );

`ifdef PC_SEQUENCER_EXC_EN
    logic [31:0] epc_q;
    logic [31:0] epc_d;
    logic        misaligned;
    logic        trap_entry;

    assign misaligned = i_pcsrc && (i_nextpc[1:0] != 2'b00);
    assign trap_entry = ((state_q == ST_FETCH) && tmo_expired) || (advance && misaligned);
    assign o_epc      = epc_q;

    // Faulting PC capture on the edge that enters TRAP.
    always_comb begin
        epc_d = epc_q;
        if (trap_entry) begin
            epc_d = pc_q;
        end
    end

    // Exception PC register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            epc_q <= '0;
        end else begin
            epc_q <= epc_d;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^EXC_VECTOR;
    assign o_epc      = '0;
    assign o_trap     = 1'b0;
`endif

    // State, PC and instruction registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            started_q <= 1'b0;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
        end
    end

    // Next-state logic; IDLE waits for the first edge to register the reset release.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (started_q) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (ack_take) begin
                    state_d = ST_EXEC;
`ifdef PC_SEQUENCER_EXC_EN
                end else if (tmo_expired) begin
                    state_d = ST_TRAP;
`endif
                end
            end
            ST_EXEC: begin
                if (advance) begin
`ifdef PC_SEQUENCER_EXC_EN
                    state_d = misaligned ? ST_TRAP : ST_FETCH;
`else
                    state_d = ST_FETCH;
`endif
                end
            end
`ifdef PC_SEQUENCER_EXC_EN
            ST_TRAP: state_d = ST_FETCH;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: instruction capture on ack, PC step/redirect on completion.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        if ((state_q == ST_FETCH) && ack_take) begin
            instr_d = i_imem_data;
        end
        if (advance) begin
            pc_d = i_pcsrc ? redir_pc : pc_plus4;
        end
`ifdef PC_SEQUENCER_EXC_EN
        if (trap_entry) begin
            pc_d = EXC_VECTOR;
        end
`endif
    end

    // Outputs decoded from state; the request drops in the expiry cycle.
    always_comb begin
        o_imem_req    = 1'b0;
        o_instr_valid = 1'b0;
`ifdef PC_SEQUENCER_EXC_EN
        o_trap        = 1'b0;
`endif
        case (state_q)
            ST_FETCH: o_imem_req    = !tmo_expired;
            ST_EXEC:  o_instr_valid = 1'b1;
`ifdef PC_SEQUENCER_EXC_EN
            ST_TRAP:  o_trap        = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed boundary cases followed by random
// fetch/execute traffic checked against a transaction-level PC model.
// Follows PC_SEQUENCER_EXC_EN the same way as the design.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TIMEOUT  = 16;
    localparam logic [31:0] EXC_VEC  = 32'h8000_0180;
`ifdef PC_SEQUENCER_EXC_EN
    localparam bit EXC = 1'b1;
`else
    localparam bit EXC = 1'b0;
`endif

    logic        i_clk;
    logic        i_rst_n;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_data;
    logic [31:0] o_instr;
    logic        o_instr_valid;
    logic        i_exec_done;
    logic        i_stall;
    logic        i_pcsrc;
    logic [31:0] i_nextpc;
    logic [31:0] o_pc;
    logic [31:0] o_pc_plus4;
    logic        o_trap;
    logic [31:0] o_epc;

    int          n_checks;
    int          n_pass;
    logic [31:0] model_pc;
    logic [31:0] cur_instr;
    logic [31:0] exp_q[$];

    pc_sequencer #(
        .RESET_PC   (RESET_PC),
        .TIMEOUT    (TIMEOUT),
        .EXC_VECTOR (EXC_VEC)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_ack    (i_imem_ack),
        .i_imem_data   (i_imem_data),
        .o_instr       (o_instr),
        .o_instr_valid (o_instr_valid),
        .i_exec_done   (i_exec_done),
        .i_stall       (i_stall),
        .i_pcsrc       (i_pcsrc),
        .i_nextpc      (i_nextpc),
        .o_pc          (o_pc),
        .o_pc_plus4    (o_pc_plus4),
        .o_trap        (o_trap),
        .o_epc         (o_epc)
    );

    // Clock and watchdog.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge where a fetch is due; acks after 'delay' extra request cycles.
    task automatic do_fetch(input logic [31:0] data, input int delay);
        int          waited;
        logic [31:0] want;
        waited = 0;
        i_imem_ack = 1'b0;
        while (o_imem_req !== 1'b1 && waited < 4) begin
            @(negedge i_clk);
            waited++;
        end
        want = exp_q.pop_front();
        check_eq("fetch_req", 32'(o_imem_req), 32'd1);
        check_eq("fetch_addr", o_imem_addr, want);
        repeat (delay) begin
            @(negedge i_clk);
            check_eq("req_hold", 32'(o_imem_req), 32'd1);
            check_eq("addr_hold", o_imem_addr, want);
        end
        i_imem_ack  = 1'b1;
        i_imem_data = data;
        @(negedge i_clk);
        i_imem_ack  = 1'b0;
        i_imem_data = $urandom;
        cur_instr   = data;
        check_eq("exec_valid", 32'(o_instr_valid), 32'd1);
        check_eq("exec_instr", o_instr, data);
        check_eq("exec_noreq", 32'(o_imem_req), 32'd0);
    endtask

    // Called at a negedge in EXEC; completes the instruction and updates the model.
    task automatic do_exec(input int idle, input int stall, input logic pcsrc, input logic [31:0] nextpc);
        logic [31:0] pc_before;
        pc_before = model_pc;
        repeat (idle) begin
            i_exec_done = 1'b0;
            i_stall     = 1'($urandom_range(0, 1));
            i_imem_ack  = 1'($urandom_range(0, 1));
            i_imem_data = $urandom;
            i_pcsrc     = 1'($urandom_range(0, 1));
            i_nextpc    = $urandom;
            @(negedge i_clk);
            check_eq("idle_valid", 32'(o_instr_valid), 32'd1);
            check_eq("idle_instr", o_instr, cur_instr);
            check_eq("idle_pc", o_pc, model_pc);
        end
        i_imem_ack = 1'b0;
        repeat (stall) begin
            i_exec_done = 1'b1;
            i_stall     = 1'b1;
            @(negedge i_clk);
            check_eq("stall_pc", o_pc, model_pc);
            check_eq("stall_valid", 32'(o_instr_valid), 32'd1);
        end
        i_exec_done = 1'b1;
        i_stall     = 1'b0;
        i_pcsrc     = pcsrc;
        i_nextpc    = nextpc;
        @(negedge i_clk);
        i_exec_done = 1'b0;
        i_pcsrc     = 1'b0;
        check_eq("done_valid", 32'(o_instr_valid), 32'd0);
        if (EXC && pcsrc && (nextpc[1:0] != 2'b00)) begin
            check_eq("trap_pulse", 32'(o_trap), 32'd1);
            check_eq("trap_epc", o_epc, pc_before);
            check_eq("trap_pc", o_pc, EXC_VEC);
            check_eq("trap_noreq", 32'(o_imem_req), 32'd0);
            model_pc = EXC_VEC;
            exp_q.push_back(model_pc);
            @(negedge i_clk);
            check_eq("trap_end", 32'(o_trap), 32'd0);
        end else begin
            if (pcsrc) model_pc = {nextpc[31:2], 2'b00};
            else       model_pc = model_pc + 32'd4;
            exp_q.push_back(model_pc);
            check_eq("next_pc", o_pc, model_pc);
            check_eq("next_pc4", o_pc_plus4, model_pc + 32'd4);
            check_eq("no_trap", 32'(o_trap), 32'd0);
        end
    endtask

    // Called at the negedge of the first request cycle; never acks.
    task automatic do_timeout();
        logic [31:0] want;
        want = exp_q.pop_front();
        check_eq("tmo_req0", 32'(o_imem_req), 32'd1);
        check_eq("tmo_addr0", o_imem_addr, want);
        repeat (TIMEOUT - 1) begin
            @(negedge i_clk);
            check_eq("tmo_req", 32'(o_imem_req), 32'd1);
        end
        @(negedge i_clk);
        check_eq("tmo_drop", 32'(o_imem_req), 32'd0);
        if (EXC) begin
            @(negedge i_clk);
            check_eq("tmo_trap", 32'(o_trap), 32'd1);
            check_eq("tmo_epc", o_epc, want);
            check_eq("tmo_vec", o_pc, EXC_VEC);
            model_pc = EXC_VEC;
            exp_q.push_back(model_pc);
            @(negedge i_clk);
        end else begin
            check_eq("tmo_pc", o_pc, want);
            exp_q.push_back(want);
            @(negedge i_clk);
            check_eq("tmo_notrap", 32'(o_trap), 32'd0);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_req"}, 32'(o_imem_req), 32'd0);
        check_eq({tag, "_pc"}, o_pc, RESET_PC);
        check_eq({tag, "_instr"}, o_instr, 32'd0);
        check_eq({tag, "_valid"}, 32'(o_instr_valid), 32'd0);
        check_eq({tag, "_trap"}, 32'(o_trap), 32'd0);
        check_eq({tag, "_epc"}, o_epc, 32'd0);
    endtask

    task automatic release_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check_eq("idle_noreq", 32'(o_imem_req), 32'd0);
        @(negedge i_clk);
        check_eq("first_req", 32'(o_imem_req), 32'd1);
        check_eq("first_addr", o_imem_addr, RESET_PC);
    endtask

    // Stimulus, scoreboard and report.
    initial begin
        logic [31:0] np;
        n_checks    = 0;
        n_pass      = 0;
        i_rst_n     = 1'b0;
        i_imem_ack  = 1'b0;
        i_imem_data = 32'd0;
        i_exec_done = 1'b0;
        i_stall     = 1'b0;
        i_pcsrc     = 1'b0;
        i_nextpc    = 32'd0;
        cur_instr   = 32'd0;
        repeat (2) @(negedge i_clk);
        check_reset_values("rst");
        check_eq("rst_pc4", o_pc_plus4, RESET_PC + 32'd4);

        release_reset();
        model_pc = RESET_PC;
        exp_q.push_back(model_pc);

        do_fetch(32'h2002_0005, 0);
        do_exec(1, 0, 1'b1, 32'h0000_0010);
        do_fetch($urandom, 2);
        do_exec(0, 0, 1'b0, 32'h0);
        do_fetch($urandom, TIMEOUT - 1);
        do_exec(2, 0, 1'b1, 32'h0000_0040);
        do_fetch($urandom, 1);
        do_exec(0, 3, 1'b0, 32'h0);
        do_fetch($urandom, 0);
        do_exec(0, 0, 1'b1, 32'hFFFF_FFFC);
        do_fetch($urandom, 0);
        do_exec(0, 0, 1'b0, 32'h0);
        do_fetch($urandom, 0);
        do_exec(0, 0, 1'b1, 32'h0000_0020);
        do_timeout();
        do_fetch($urandom, 0);
        do_exec(0, 0, 1'b1, 32'h0000_0103);
        do_fetch($urandom, 0);

        for (int i = 0; i < 25; i++) begin
            np = $urandom;
            if ($urandom_range(0, 3) != 0) np[1:0] = 2'b00;
            do_exec($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), np);
            do_fetch($urandom, $urandom_range(0, TIMEOUT - 1));
        end

        do_exec(0, 0, 1'b0, 32'h0);
        check_eq("pre_rst_req", 32'(o_imem_req), 32'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        exp_q.delete();
        release_reset();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
